// File: rtl/ans_freq_table_pkg.sv
// Shared widths and state encoding for the ANS frequency table and its decoder.
package ans_freq_table_pkg;
  localparam int SYM_WIDTH   = 4;
  localparam int CNT_WIDTH   = 8;
  localparam int SYM_COUNT   = 1 << SYM_WIDTH;
  localparam int NIB_PER_SYM = CNT_WIDTH / SYM_WIDTH;
  localparam int NIB_TOTAL   = SYM_COUNT * NIB_PER_SYM;
  // Sum of SYM_COUNT counts cannot exceed CNT_WIDTH+SYM_WIDTH bits.
  localparam int SUM_WIDTH   = CNT_WIDTH + SYM_WIDTH;
  localparam int PTR_WIDTH   = $clog2(NIB_TOTAL);
  localparam int IDX_WIDTH   = SYM_WIDTH;

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;
  localparam logic [1:0] ST_ERROR = 2'd3;
endpackage

// File: rtl/ans_freq_table.sv
// Loads per-symbol counts nibble by nibble, then builds the inclusive prefix
// sum one entry per enabled cycle with a single adder.
module ans_freq_table
  import ans_freq_table_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           ena,
  input  logic                           clear,
  input  logic [SYM_WIDTH-1:0]           in,
  input  logic                           in_vld,
  output logic                           in_rdy,
  output logic [CNT_WIDTH*SYM_COUNT-1:0] counts_unpacked,
  output logic [SUM_WIDTH*SYM_COUNT-1:0] cumulative_unpacked,
  output logic                           table_vld,
  output logic                           table_err
);

  localparam logic [PTR_WIDTH-1:0] PTR_LAST = PTR_WIDTH'(NIB_TOTAL - 1);
  localparam logic [IDX_WIDTH-1:0] IDX_LAST = IDX_WIDTH'(SYM_COUNT - 1);

  logic [1:0]                     state_q, state_d;
  logic [PTR_WIDTH-1:0]           ptr_q, ptr_d;
  logic [IDX_WIDTH-1:0]           idx_q, idx_d;
  logic [SUM_WIDTH-1:0]           sum_q, sum_d;
  logic [CNT_WIDTH*SYM_COUNT-1:0] counts_q, counts_d;
  logic [SUM_WIDTH*SYM_COUNT-1:0] cum_q, cum_d;
  logic                           in_rdy_q, in_rdy_d;
  logic                           vld_q, vld_d;
  logic                           err_q, err_d;
  logic [CNT_WIDTH-1:0]           cnt_cur;
  logic [SUM_WIDTH-1:0]           sum_nxt;

  // Running sum: the count at the current index added to everything before it.
  always_comb begin
    cnt_cur = counts_q[int'(idx_q)*CNT_WIDTH +: CNT_WIDTH];
    sum_nxt = sum_q + SUM_WIDTH'(cnt_cur);
  end

  // Next-state: clear wins over any transfer; ena low freezes everything.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    sum_d    = sum_q;
    counts_d = counts_q;
    cum_d    = cum_q;
    in_rdy_d = in_rdy_q;
    vld_d    = vld_q;
    err_d    = err_q;
    if (ena) begin
      if (clear) begin
        state_d  = ST_LOAD;
        ptr_d    = '0;
        idx_d    = '0;
        sum_d    = '0;
        counts_d = '0;
        cum_d    = '0;
        in_rdy_d = 1'b1;
        vld_d    = 1'b0;
        err_d    = 1'b0;
      end else begin
        case (state_q)
          ST_LOAD: begin
            if (in_vld && in_rdy_q) begin
              counts_d[int'(ptr_q)*SYM_WIDTH +: SYM_WIDTH] = in;
              if (ptr_q == PTR_LAST) begin
                ptr_d    = '0;
                state_d  = ST_ACCUM;
                in_rdy_d = 1'b0;
              end else begin
                ptr_d = ptr_q + PTR_WIDTH'(1);
              end
            end
          end
          ST_ACCUM: begin
            cum_d[int'(idx_q)*SUM_WIDTH +: SUM_WIDTH] = sum_nxt;
            sum_d = sum_nxt;
            if (idx_q == IDX_LAST) begin
              idx_d = '0;
              if (sum_nxt != '0) begin
                state_d = ST_READY;
                vld_d   = 1'b1;
              end else begin
                state_d = ST_ERROR;
                err_d   = 1'b1;
              end
            end else begin
              idx_d = idx_q + IDX_WIDTH'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // State registers; reset lands in LOAD ready to accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_LOAD;
      ptr_q    <= '0;
      idx_q    <= '0;
      sum_q    <= '0;
      counts_q <= '0;
      cum_q    <= '0;
      in_rdy_q <= 1'b1;
      vld_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      sum_q    <= sum_d;
      counts_q <= counts_d;
      cum_q    <= cum_d;
      in_rdy_q <= in_rdy_d;
      vld_q    <= vld_d;
      err_q    <= err_d;
    end
  end

  assign in_rdy              = in_rdy_q;
  assign counts_unpacked     = counts_q;
  assign cumulative_unpacked = cum_q;
  assign table_vld           = vld_q;
  assign table_err           = err_q;

endmodule

// File: tb/tb_ans_freq_table.sv
// Directed bench for ans_freq_table: table of count patterns plus hand-written
// stall, clear-collision and mid-accumulate reset sequences.
module tb_ans_freq_table;
  import ans_freq_table_pkg::*;

  logic                           clk = 1'b0;
  logic                           rst_n = 1'b0;
  logic                           ena = 1'b0;
  logic                           clear = 1'b0;
  logic [SYM_WIDTH-1:0]           in = '0;
  logic                           in_vld = 1'b0;
  logic                           in_rdy;
  logic [CNT_WIDTH*SYM_COUNT-1:0] counts_unpacked;
  logic [SUM_WIDTH*SYM_COUNT-1:0] cumulative_unpacked;
  logic                           table_vld;
  logic                           table_err;

  int checks = 0;
  int failures = 0;

  ans_freq_table dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .ena                 (ena),
    .clear               (clear),
    .in                  (in),
    .in_vld              (in_vld),
    .in_rdy              (in_rdy),
    .counts_unpacked     (counts_unpacked),
    .cumulative_unpacked (cumulative_unpacked),
    .table_vld           (table_vld),
    .table_err           (table_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CNT_WIDTH*SYM_COUNT-1:0] cnts;
    logic [SUM_WIDTH-1:0]           cum15;
    logic                           err;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_pulse();
    @(negedge clk);
    ena = 1'b1; clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  // Feeds all nibbles; optional random in_vld gaps and a 5-cycle ena drop
  // just before nibble stall_nib. Returns at the negedge after the last accept.
  task automatic do_load(input logic [CNT_WIDTH*SYM_COUNT-1:0] cnts,
                         input bit gaps, input int stall_nib);
    int guard;
    for (int i = 0; i < NIB_TOTAL; i++) begin
      if (i == stall_nib) begin
        in = cnts[i*SYM_WIDTH +: SYM_WIDTH];
        in_vld = 1'b1; ena = 1'b0;
        repeat (5) @(negedge clk);
        ena = 1'b1;
      end
      if (gaps) begin
        in_vld = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      in = cnts[i*SYM_WIDTH +: SYM_WIDTH];
      in_vld = 1'b1;
      guard = 0;
      while (!(in_rdy && ena) && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 50) begin
        chk("load_timeout", 32'(guard), 32'd0);
        in_vld = 1'b0;
        return;
      end
      @(negedge clk);
    end
    in_vld = 1'b0;
  endtask

  // Counts edges from the last accept until vld/err; optional ena drop mid-ACCUM.
  task automatic wait_done(input bit stall, output int lat);
    lat = 0;
    while (!(table_vld || table_err) && lat < 100) begin
      if (stall && lat == 4) begin
        ena = 1'b0;
        repeat (5) @(negedge clk);
        lat += 5;
        ena = 1'b1;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_tables(input string tag, input logic [CNT_WIDTH*SYM_COUNT-1:0] cnts);
    logic [SUM_WIDTH-1:0] s;
    int bad;
    s = '0;
    bad = 0;
    for (int j = 0; j < SYM_COUNT; j++) begin
      s = s + SUM_WIDTH'(cnts[j*CNT_WIDTH +: CNT_WIDTH]);
      if (cumulative_unpacked[j*SUM_WIDTH +: SUM_WIDTH] !== s) bad++;
    end
    chk({tag, "_cum_entries_bad"}, 32'(bad), 32'd0);
    chk({tag, "_counts_match"}, 32'(counts_unpacked == cnts), 32'd1);
  endtask

  task automatic run_vec(input string tag, input vec_t v, input bit gaps,
                         input int stall_nib, input bit stall_acc, input int exp_lat);
    int lat;
    clear_pulse();
    chk({tag, "_clear_rdy"}, 32'(in_rdy), 32'd1);
    do_load(v.cnts, gaps, stall_nib);
    chk({tag, "_rdy_low_after_last"}, 32'(in_rdy), 32'd0);
    wait_done(stall_acc, lat);
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_vld"}, 32'(table_vld), 32'(!v.err));
    chk({tag, "_err"}, 32'(table_err), 32'(v.err));
    chk({tag, "_cum15"}, 32'(cumulative_unpacked[15*SUM_WIDTH +: SUM_WIDTH]), 32'(v.cum15));
    check_tables(tag, v.cnts);
    // In READY/ERROR the tables hold and in_vld is ignored.
    in_vld = 1'b1; in = 4'hF;
    repeat (3) @(negedge clk);
    in_vld = 1'b0;
    chk({tag, "_hold_rdy"}, 32'(in_rdy), 32'd0);
    check_tables({tag, "_hold"}, v.cnts);
  endtask

  initial begin
    logic [CNT_WIDTH*SYM_COUNT-1:0] c;
    int lat;

    // Vector table: count patterns with hand-computed cum[15] and error flag.
    c = '0; for (int j = 0; j < SYM_COUNT; j++) c[j*CNT_WIDTH +: CNT_WIDTH] = 8'd1;
    vecs[0] = '{c, 12'd16, 1'b0};
    c = '0; c[0 +: 8] = 8'd255; c[15*8 +: 8] = 8'd255;
    vecs[1] = '{c, 12'd510, 1'b0};
    c = '0;
    vecs[2] = '{c, 12'd0, 1'b1};
    c = '0; for (int j = 0; j < SYM_COUNT; j++) c[j*CNT_WIDTH +: CNT_WIDTH] = 8'(j + 1);
    vecs[3] = '{c, 12'd136, 1'b0};
    c = '0; for (int j = 0; j < SYM_COUNT; j++) c[j*CNT_WIDTH +: CNT_WIDTH] = 8'(17 * j);
    vecs[4] = '{c, 12'd2040, 1'b0};
    c = '0; c[7*8 +: 8] = 8'd3;
    vecs[5] = '{c, 12'd3, 1'b0};

    // Reset state
    #12;
    chk("reset_rdy", 32'(in_rdy), 32'd1);
    chk("reset_vld", 32'(table_vld), 32'd0);
    chk("reset_err", 32'(table_err), 32'd0);
    chk("reset_counts_zero", 32'(counts_unpacked == '0), 32'd1);
    chk("reset_cum_zero", 32'(cumulative_unpacked == '0), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    ena = 1'b1;

    // First transfer at the first enabled edge after release
    in = 4'h9; in_vld = 1'b1;
    @(negedge clk);
    in_vld = 1'b0;
    chk("first_xfer_nibble", 32'(counts_unpacked[3:0]), 32'h9);

    for (int k = 0; k < 6; k++)
      run_vec($sformatf("vec%0d", k), vecs[k], 1'b0, -1, 1'b0, 16);

    // After the error vector, clear returns to LOAD with err dropped
    run_vec("err_again", vecs[2], 1'b0, -1, 1'b0, 16);
    clear_pulse();
    chk("err_clear_rdy", 32'(in_rdy), 32'd1);
    chk("err_clear_err", 32'(table_err), 32'd0);
    chk("err_clear_vld", 32'(table_vld), 32'd0);

    // Gaps and ena stalls: same tables, latency grows by the 5 stalled cycles
    run_vec("stall", vecs[3], 1'b1, 12, 1'b1, 21);

    // Unwritten cum entries read zero mid-ACCUM
    clear_pulse();
    do_load(vecs[0].cnts, 1'b0, -1);
    repeat (2) @(negedge clk);
    chk("accum_cum1", 32'(cumulative_unpacked[1*SUM_WIDTH +: SUM_WIDTH]), 32'd2);
    chk("accum_cum5_unwritten", 32'(cumulative_unpacked[5*SUM_WIDTH +: SUM_WIDTH]), 32'd0);
    chk("accum_vld_low", 32'(table_vld), 32'd0);

    // clear collides with nibble 10: dropped, pointer back to 0
    clear_pulse();
    for (int i = 0; i < 10; i++) begin
      in = vecs[0].cnts[i*SYM_WIDTH +: SYM_WIDTH]; in_vld = 1'b1;
      @(negedge clk);
    end
    chk("pre_clear_count4", 32'(counts_unpacked[4*8 +: 8]), 32'd1);
    in = 4'h7; in_vld = 1'b1; clear = 1'b1;
    @(negedge clk);
    clear = 1'b0; in_vld = 1'b0;
    chk("collide_rdy", 32'(in_rdy), 32'd1);
    chk("collide_counts_zero", 32'(counts_unpacked == '0), 32'd1);
    do_load(vecs[3].cnts, 1'b0, -1);
    wait_done(1'b0, lat);
    chk("collide_reload_vld", 32'(table_vld), 32'd1);
    chk("collide_reload_cum15", 32'(cumulative_unpacked[15*SUM_WIDTH +: SUM_WIDTH]), 32'd136);
    check_tables("collide_reload", vecs[3].cnts);

    // Asynchronous reset mid-ACCUM
    clear_pulse();
    do_load(vecs[4].cnts, 1'b0, -1);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rdy", 32'(in_rdy), 32'd1);
    chk("arst_vld", 32'(table_vld), 32'd0);
    chk("arst_err", 32'(table_err), 32'd0);
    chk("arst_counts_zero", 32'(counts_unpacked == '0), 32'd1);
    chk("arst_cum_zero", 32'(cumulative_unpacked == '0), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    do_load(vecs[5].cnts, 1'b0, -1);
    wait_done(1'b0, lat);
    chk("arst_reload_latency", 32'(lat), 32'd16);
    chk("arst_reload_vld", 32'(table_vld), 32'd1);
    check_tables("arst_reload", vecs[5].cnts);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global bound so the run always ends
  initial begin
    #500000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ans_freq_table.md
ANS_FREQ_TABLE -- requirements
Module: ans_freq_table

Interface
REQ-001 SHALL use shared macros: SYM_WIDTH = nibble width (4), CNT_WIDTH = per-symbol count width (multiple of SYM_WIDTH), SYM_COUNT = number of symbols (2^SYM_WIDTH).
REQ-002 SHALL have one clock; reset is asynchronous and active-low (ports clk, rst_n).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 ena  input  1  clock enable; low freezes all state and outputs.
REQ-006 clear  input  1  synchronous request to discard the table and reload.
REQ-007 in  input  SYM_WIDTH  count nibble from the host stream.
REQ-008 in_vld  input  1  in carries a valid nibble.
REQ-009 in_rdy  output  1  registered; block accepts a nibble.
REQ-010 counts_unpacked  output  CNT_WIDTH*SYM_COUNT  count[j] at bits j*CNT_WIDTH +: CNT_WIDTH.
REQ-011 cumulative_unpacked  output  (CNT_WIDTH+SYM_WIDTH)*SYM_COUNT  inclusive prefix sum cum[j] = count[0]+...+count[j], same packing.
REQ-012 table_vld  output  1  both tables complete and usable by the decoder.
REQ-013 table_err  output  1  loaded table sums to zero; unusable.

Function
REQ-014 States: LOAD, ACCUM, READY, ERROR; encoding held in the shared package.
REQ-015 LOAD: in_rdy=1; nibble accepted at a rising edge with ena && in_vld && in_rdy.
REQ-016 Load order: symbol 0 first; within a count, least-significant nibble first; CNT_WIDTH/SYM_WIDTH nibbles per symbol; SYM_COUNT*CNT_WIDTH/SYM_WIDTH nibbles total.
REQ-017 Accepted nibble written directly into counts_unpacked at its slot; no other count bits change.
REQ-018 At the edge accepting the final nibble (edge N), state -> ACCUM and in_rdy -> 0.
REQ-019 ACCUM: one entry per enabled cycle; cum[k] written at edge N+1+k, k = 0..SYM_COUNT-1, using a CNT_WIDTH+SYM_WIDTH-bit running sum (no overflow possible).
REQ-020 At edge N+SYM_COUNT: if cum[SYM_COUNT-1] != 0, state -> READY and table_vld -> 1; otherwise state -> ERROR and table_err -> 1, table_vld stays 0.
REQ-021 READY/ERROR: in_rdy=0, tables held stable; in_vld ignored.
REQ-022 Zero counts for individual symbols are legal (cum repeats previous value).
REQ-023 clear (with ena) in any state: next edge -> LOAD, in_rdy=1, table_vld=0, table_err=0, nibble pointer and accumulator index=0, counts and cumulative zeroed.
REQ-024 clear has priority over a simultaneous nibble transfer; that nibble is dropped and not consumed.
REQ-025 ena low during LOAD or ACCUM: pointer, index, sum hold; no transfer occurs even if in_vld && in_rdy.
REQ-026 cumulative_unpacked entries not yet written in ACCUM read 0; only table_vld qualifies outputs.

Reset
REQ-027 rst_n low, at any time including mid-load or mid-ACCUM: state=LOAD, in_rdy=1, table_vld=0, table_err=0, counts_unpacked=0, cumulative_unpacked=0, pointer/index/sum=0.
REQ-028 After reset release, first transfer possible at the first enabled edge.

Structure
REQ-029 State enum and SYM_WIDTH/CNT_WIDTH/SYM_COUNT macros SHALL live in the shared package/defines header used by the decoder.
REQ-030 Single module, no sub-module; prefix sum is sequential (one adder), not a combinational chain.

Verification (SYM_WIDTH=4, CNT_WIDTH=8, SYM_COUNT=16)
REQ-031 All counts 1 (32 nibbles 1,0,...) -> cum[j]=j+1, cum[15]=16, table_vld rises exactly 16 cycles after the last accept.
REQ-032 count[0]=255, count[15]=255, rest 0 -> cum[0..14]=255, cum[15]=510 (no truncation), table_vld=1.
REQ-033 All counts 0 -> table_err=1, table_vld=0, in_rdy=0; then clear -> LOAD, table_err=0 next cycle.
REQ-034 Random in_vld gaps plus ena low for 5 cycles mid-load and mid-ACCUM -> tables identical to gap-free run, latency extended by stalled cycles only.
REQ-035 clear asserted same cycle as nibble 10 transfer -> nibble dropped, pointer 0; full reload of counts 1..16 -> cum[15]=136.
REQ-036 rst_n pulsed low during ACCUM -> all outputs zero asynchronously, in_rdy=1; subsequent load completes correctly.
